imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle MIPS processor. It receives a byte stream over a valid/ready handshake, assembles the bytes into 32-bit big-endian instruction words, and writes them into the processor's instruction memory at sequential word-aligned byte addresses. The processor is held in reset until the load completes. The processor fetches from instruction memory; this block is the writer that fills it.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.
- MAX_WORDS, 256: instruction memory depth in words. Words at index ≥ MAX_WORDS are dropped.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- start  in  1  single-cycle pulse; restarts a load from DONE.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  32  write byte address, word-aligned.
- imem_wdata  out  32  write data.
- cpu_reset  out  1  held high while loading; drives the processor's reset.
- done  out  1  load complete.
- error  out  1  sticky: the header count exceeded MAX_WORDS.
- words_loaded  out  16  words written so far in this load.

## Operation

- Stream format: 2-byte word count N (big-endian), then N×4 instruction bytes. Each word is big-endian: the first byte goes to [31:24].
- A byte transfers on a rising edge when in_valid && in_ready.
- FSM states: HDR_HI, HDR_LO, DATA, DONE.
  - HDR_HI: the accepted byte becomes count[15:8]. Go to HDR_LO.
  - HDR_LO: the accepted byte becomes count[7:0]. If the full count is 0, go to DONE. Otherwise go to DATA with byte_idx=0 and word_idx=0.
  - DATA: each accepted byte shifts into the word assembler, and byte_idx increments modulo 4. On the 4th byte:
    - If word_idx < MAX_WORDS, write the word and increment words_loaded.
    - Otherwise set error and perform no write.
    - word_idx increments in both cases.
    - When word_idx reaches N, go to DONE.
  - DONE: a start pulse returns to HDR_HI. On that transition, set cpu_reset=1, clear done, error, words_loaded and the indices, and return imem_addr to BASE_ADDR. start is ignored in all other states.
- imem_addr = BASE_ADDR + 4×word_idx, registered. Address arithmetic is 32-bit and wraps modulo 2^32.
- in_ready = 1 in HDR_HI, HDR_LO and DATA. in_ready = 0 in DONE and while reset is asserted. Bytes arriving in DONE are not consumed.
- cpu_reset = 1 in every state except DONE.
- Reset mid-load: all state returns to reset values immediately and asynchronously. The partial load is abandoned, and bytes already written to memory stay.

## Timing

- Reset values:
  - state = HDR_HI
  - in_ready = 0 during reset, 1 from the first clock after release
  - imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0
  - cpu_reset = 1, done = 0, error = 0, words_loaded = 0
- Write latency: if the 4th byte of a word is accepted at edge E, then imem_we=1 with valid imem_addr and imem_wdata during the cycle after E, sampled by memory at edge E+1. imem_we is high for exactly one cycle per word.
- Throughput: one byte per cycle, with no wait states between bytes or words.
- Completion: if the last word's write pulse is in cycle C, then done=1 and cpu_reset=0 from cycle C+1. For N=0, done rises the cycle after the HDR_LO byte is accepted.
- words_loaded updates on the same edge that raises imem_we.
- error rises on the edge that would have raised imem_we for the first dropped word.
- Gaps in in_valid stall the assembler without losing bytes.

## Test plan

- Reset: assert reset, then check in_ready=0, cpu_reset=1, done=0, imem_we=0 and imem_addr=0. Release reset, then check in_ready=1 on the next cycle.
- Basic load, stream 00 03 then 20 08 00 05 / 20 09 00 07 / 01 09 50 20:
  - Exactly three imem_we pulses occur: (0x0, 0x20080005), (0x4, 0x20090007), (0x8, 0x01095020).
  - done=1 and cpu_reset=0 one cycle after the third pulse.
  - words_loaded=3.
- Empty load, stream 00 00: no imem_we pulse. done=1 the cycle after the second byte. in_ready=0 afterwards.
- Backpressure, same stream as the basic load but in_valid toggled 1/0 each cycle: identical writes and data as the basic load, with pulses spaced at least 8 cycles apart.
- Overflow, MAX_WORDS=2, stream 00 03 plus 12 bytes: two writes at 0x0 and 0x4. The third word is consumed without a write. error=1, done=1, words_loaded=2.
- Reload and mid-load reset:
  - After done, pulse start: cpu_reset=1, done=0, error=0, and a second stream rewrites from BASE_ADDR.
  - Assert reset after 5 data bytes: all outputs return to reset values, and a new header starts cleanly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction-memory loader.
// The master is the byte source and the slave is the loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a counted big-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  imem_loader_if.slave       s_in,
  input  logic               start,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded
);

  typedef enum logic [1:0] {S_HDR_HI, S_HDR_LO, S_DATA, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ready;
  logic        r_fin;
  logic        r_we;
  logic        r_error;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [15:0] r_words;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic w_accept;
  logic w_word_end;
  logic w_last_byte;
  logic w_in_range;

  assign w_accept    = s_in.in_valid && r_ready;
  assign w_word_end  = w_accept && (r_state == S_DATA) && (r_byte_idx == 2'd3);
  assign w_last_byte = w_word_end && ((r_word_idx + 16'd1) == r_count);
  assign w_in_range  = {16'd0, r_word_idx} < MAX_WORDS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HDR_HI;
    else       r_state <= w_state_nxt;
  end

  // The last word's write pulse gets its own cycle in DATA (r_fin) so that
  // done rises only after memory has sampled it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR_HI: if (w_accept) w_state_nxt = S_HDR_LO;
      S_HDR_LO: if (w_accept)
                  w_state_nxt = ({r_count[15:8], s_in.in_data} == 16'd0) ? S_DONE : S_DATA;
      S_DATA:   if (r_fin) w_state_nxt = S_DONE;
      S_DONE:   if (start) w_state_nxt = S_HDR_HI;
      default:  w_state_nxt = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_fin      <= 1'b0;
      r_we       <= 1'b0;
      r_error    <= 1'b0;
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_words    <= 16'd0;
      r_byte_idx <= 2'd0;
      r_shift    <= 24'd0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'd0;
    end else begin
      r_ready <= (w_state_nxt != S_DONE) && !w_last_byte;
      r_we    <= 1'b0;
      case (r_state)
        S_HDR_HI: if (w_accept) r_count[15:8] <= s_in.in_data;
        S_HDR_LO: if (w_accept) begin
          r_count[7:0] <= s_in.in_data;
          r_byte_idx   <= 2'd0;
          r_word_idx   <= 16'd0;
          r_fin        <= 1'b0;
        end
        S_DATA: if (w_accept) begin
          r_byte_idx <= r_byte_idx + 2'd1;
          r_shift    <= {r_shift[15:0], s_in.in_data};
          if (w_word_end) begin
            r_word_idx <= r_word_idx + 16'd1;
            r_addr     <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
            if (w_in_range) begin
              r_we    <= 1'b1;
              r_wdata <= {r_shift, s_in.in_data};
              r_words <= r_words + 16'd1;
            end else begin
              r_error <= 1'b1;
            end
            if (w_last_byte) r_fin <= 1'b1;
          end
        end
        S_DONE: if (start) begin
          r_error    <= 1'b0;
          r_words    <= 16'd0;
          r_word_idx <= 16'd0;
          r_byte_idx <= 2'd0;
          r_fin      <= 1'b0;
          r_addr     <= BASE_ADDR;
        end
        default: ;
      endcase
    end
  end

  assign s_in.in_ready = r_ready;
  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign cpu_reset     = (r_state != S_DONE);
  assign done          = (r_state == S_DONE);
  assign error         = r_error;
  assign words_loaded  = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: main instance (MAX_WORDS=256) and a
// second instance with MAX_WORDS=2 for the overflow case.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  imem_loader_if s_if ();
  imem_loader_if o_if ();

  logic        we0, cpur0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [15:0] words0;
  logic        we1, cpur1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [15:0] words1;

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .s_in(s_if), .start(start),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .cpu_reset(cpur0), .done(done0), .error(err0), .words_loaded(words0)
  );

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(2)) dut_ov (
    .clk(clk), .reset(reset), .s_in(o_if), .start(start),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .cpu_reset(cpur1), .done(done1), .error(err1), .words_loaded(words1)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] m_addr0 [16];
  logic [31:0] m_data0 [16];
  int          m_cyc0  [16];
  int          m_cnt0 = 0;
  logic [31:0] m_addr1 [16];
  logic [31:0] m_data1 [16];
  int          m_cnt1 = 0;

  logic [7:0] bq [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) begin
      if (m_cnt0 < 16) begin
        m_addr0[m_cnt0] = addr0;
        m_data0[m_cnt0] = wdata0;
        m_cyc0[m_cnt0]  = cyc;
      end
      m_cnt0 = m_cnt0 + 1;
    end
    if (we1) begin
      if (m_cnt1 < 16) begin
        m_addr1[m_cnt1] = addr1;
        m_data1[m_cnt1] = wdata1;
      end
      m_cnt1 = m_cnt1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents one byte and holds it until accepted; returns 1ns after the
  // accepting edge with in_valid dropped.
  task automatic send_byte(input bit ov, input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    if (ov) begin o_if.in_data = b; o_if.in_valid = 1'b1; end
    else    begin s_if.in_data = b; s_if.in_valid = 1'b1; end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ov ? o_if.in_ready : s_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (ov) o_if.in_valid = 1'b0;
    else    s_if.in_valid = 1'b0;
    chk("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_stream(input bit ov, input bit gap);
    for (int i = 0; i < bq.size(); i++) begin
      send_byte(ov, bq[i]);
      if (gap && i != bq.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_basic_writes(input int b);
    chk("pulse_count", m_cnt0 - b, 3);
    chk("w0_addr", m_addr0[b],   32'h0000_0000);
    chk("w0_data", m_data0[b],   32'h2008_0005);
    chk("w1_addr", m_addr0[b+1], 32'h0000_0004);
    chk("w1_data", m_data0[b+1], 32'h2009_0007);
    chk("w2_addr", m_addr0[b+2], 32'h0000_0008);
    chk("w2_data", m_data0[b+2], 32'h0109_5020);
  endtask

  task automatic load_basic_queue();
    bq = '{8'h00, 8'h03,
           8'h20, 8'h08, 8'h00, 8'h05,
           8'h20, 8'h09, 8'h00, 8'h07,
           8'h01, 8'h09, 8'h50, 8'h20};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    reset = 1'b1;
    start = 1'b0;
    s_if.in_data = 8'h00; s_if.in_valid = 1'b0;
    o_if.in_data = 8'h00; o_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",     {31'd0, s_if.in_ready}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpur0},         32'd1);
    chk("rst_done",      {31'd0, done0},         32'd0);
    chk("rst_we",        {31'd0, we0},           32'd0);
    chk("rst_addr",      addr0,                  32'h0);
    chk("rst_error",     {31'd0, err0},          32'd0);
    chk("rst_words",     {16'd0, words0},        32'd0);
    reset = 1'b0;
    #1;
    chk("ready_at_release", {31'd0, s_if.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_release", {31'd0, s_if.in_ready}, 32'd1);

    // Basic load
    b = m_cnt0;
    load_basic_queue();
    send_stream(1'b0, 1'b0);
    chk("basic_last_we",   {31'd0, we0},   32'd1);
    chk("basic_last_done", {31'd0, done0}, 32'd0);
    @(posedge clk);
    #1;
    chk("basic_done",      {31'd0, done0}, 32'd1);
    chk("basic_cpu_reset", {31'd0, cpur0}, 32'd0);
    chk("basic_we_low",    {31'd0, we0},   32'd0);
    chk("basic_words",     {16'd0, words0}, 32'd3);
    chk("basic_ready_low", {31'd0, s_if.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_basic_writes(b);

    // Reload with backpressure
    pulse_start();
    chk("reload_cpu_reset", {31'd0, cpur0},  32'd1);
    chk("reload_done",      {31'd0, done0},  32'd0);
    chk("reload_error",     {31'd0, err0},   32'd0);
    chk("reload_words",     {16'd0, words0}, 32'd0);
    chk("reload_addr",      addr0,           32'h0);
    chk("reload_ready",     {31'd0, s_if.in_ready}, 32'd1);
    b = m_cnt0;
    load_basic_queue();
    send_stream(1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_done",  {31'd0, done0},  32'd1);
    chk("bp_words", {16'd0, words0}, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check_basic_writes(b);
    chk("bp_gap01", {31'd0, (m_cyc0[b+1] - m_cyc0[b]) >= 8},   32'd1);
    chk("bp_gap12", {31'd0, (m_cyc0[b+2] - m_cyc0[b+1]) >= 8}, 32'd1);

    // Empty load
    pulse_start();
    b = m_cnt0;
    bq = '{8'h00, 8'h00};
    send_stream(1'b0, 1'b0);
    chk("empty_done",      {31'd0, done0}, 32'd1);
    chk("empty_cpu_reset", {31'd0, cpur0}, 32'd0);
    chk("empty_ready",     {31'd0, s_if.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_no_pulse", m_cnt0 - b, 0);
    chk("empty_words",    {16'd0, words0}, 32'd0);

    // Mid-load reset after 5 data bytes
    pulse_start();
    bq = '{8'h00, 8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20};
    send_stream(1'b0, 1'b0);
    chk("mid_words_before", {16'd0, words0}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready",     {31'd0, s_if.in_ready}, 32'd0);
    chk("mid_rst_cpu_reset", {31'd0, cpur0},  32'd1);
    chk("mid_rst_done",      {31'd0, done0},  32'd0);
    chk("mid_rst_we",        {31'd0, we0},    32'd0);
    chk("mid_rst_addr",      addr0,           32'h0);
    chk("mid_rst_wdata",     wdata0,          32'h0);
    chk("mid_rst_words",     {16'd0, words0}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ready_again", {31'd0, s_if.in_ready}, 32'd1);
    b = m_cnt0;
    bq = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(1'b0, 1'b0);
    chk("mid_new_we",    {31'd0, we0}, 32'd1);
    chk("mid_new_addr",  addr0,        32'h0);
    chk("mid_new_wdata", wdata0,       32'hAABB_CCDD);
    @(posedge clk);
    #1;
    chk("mid_new_done",  {31'd0, done0},  32'd1);
    chk("mid_new_words", {16'd0, words0}, 32'd1);
    chk("mid_new_pulses", m_cnt0 - b, 1);

    // Overflow on the MAX_WORDS=2 instance
    b = m_cnt1;
    bq = '{8'h00, 8'h03,
           8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC};
    send_stream(1'b1, 1'b0);
    chk("ov_last_we",    {31'd0, we1},  32'd0);
    chk("ov_error_edge", {31'd0, err1}, 32'd1);
    chk("ov_not_done",   {31'd0, done1}, 32'd0);
    @(posedge clk);
    #1;
    chk("ov_done",      {31'd0, done1},  32'd1);
    chk("ov_error",     {31'd0, err1},   32'd1);
    chk("ov_words",     {16'd0, words1}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("ov_pulses",  m_cnt1 - b,     2);
    chk("ov_w0_addr", m_addr1[b],     32'h0);
    chk("ov_w0_data", m_data1[b],     32'h1122_3344);
    chk("ov_w1_addr", m_addr1[b+1],   32'h4);
    chk("ov_w1_data", m_data1[b+1],   32'h5566_7788);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
